// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time over valid/ready, data returned LATENCY cycles later.
// Optional loader write port enabled by defining IMEM_WRITE_PORT_EN.
module imem_responder #(
  parameter int    INSTRUCTION_WIDTH = 32,
  parameter int    PC_WIDTH          = 32,
  parameter int    DEPTH             = 1024,
  parameter int    LATENCY           = 1,
  parameter string INIT_FILE         = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [PC_WIDTH-1:0]          req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [INSTRUCTION_WIDTH-1:0] rsp_data,
  output logic                         rsp_err
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic                         wr_en,
  input  logic [PC_WIDTH-1:0]          wr_addr,
  input  logic [31:0]                  wr_data,
  input  logic [3:0]                   wr_strb
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSN = INSTRUCTION_WIDTH'(32'h0000_0013);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [INSTRUCTION_WIDTH-1:0] mem_r [DEPTH];

  state_t                       state_r;
  state_t                       state_nx_s;
  logic [3:0]                   cnt_r;
  logic [3:0]                   cnt_nx_s;
  logic                         req_ready_r;
  logic                         rsp_valid_r;
  logic [INSTRUCTION_WIDTH-1:0] rsp_data_r;
  logic                         rsp_err_r;
  logic                         accept_s;
  logic [AW-1:0]                rd_idx_s;

  // A fetch is faulty when misaligned or when any address bit above the array index is set.
  function automatic logic addr_fault(input logic [PC_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != {PC_WIDTH{1'b0}});
  endfunction

  assign accept_s  = req_valid && (state_r == S_IDLE);
  assign rd_idx_s  = req_addr[AW+1:2];
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

  // Next-state and latency-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 1) begin
            state_nx_s = S_WAIT;
            cnt_nx_s   = 4'd1;
          end else begin
            state_nx_s = S_RESP;
            cnt_nx_s   = 4'd0;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == LAT_LAST) begin
          state_nx_s = S_RESP;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // State register with handshake flags decoded from the next state so they leave a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      req_ready_r <= (state_nx_s == S_IDLE);
      rsp_valid_r <= (state_nx_s == S_RESP);
    end
  end

  // Response data captured at the accept edge and held until the next accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_data_r <= NOP_INSN;
      rsp_err_r  <= 1'b0;
    end else if (accept_s) begin
      if (addr_fault(req_addr)) begin
        rsp_data_r <= NOP_INSN;
        rsp_err_r  <= 1'b1;
      end else begin
        rsp_data_r <= mem_r[rd_idx_s];
        rsp_err_r  <= 1'b0;
      end
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_err_r  <= rsp_err_r;
    end
  end

`ifdef IMEM_WRITE_PORT_EN
  logic [AW-1:0] wr_idx_s;
  assign wr_idx_s = wr_addr[AW+1:2];

  // Byte-masked loader write; non-blocking update gives read-before-write against a same-edge accept.
  always_ff @(posedge clk) begin
    if (reset && wr_en && !addr_fault(wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx_s][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1, one at LATENCY=3.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        reset1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1, rsp_data1;
  logic        reset3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] req_addr3, rsp_data3;
`ifdef IMEM_WRITE_PORT_EN
  logic        wr_en1;
  logic [31:0] wr_addr1, wr_data1;
  logic [3:0]  wr_strb1;
`endif

  imem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1)
`ifdef IMEM_WRITE_PORT_EN
    , .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_strb(wr_strb1)
`endif
  );

  imem_responder #(.LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3)
`ifdef IMEM_WRITE_PORT_EN
    , .wr_en(1'b0), .wr_addr(32'h0), .wr_data(32'h0), .wr_strb(4'h0)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // LATENCY=1 fetch with the consumer always ready.
  task automatic fetch1(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err);
    check({tag, "_req_ready"}, {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1;
    req_addr1  = addr;
    rsp_ready1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid1}, 32'd1);
    check({tag, "_rsp_data"}, rsp_data1, exp_data);
    check({tag, "_rsp_err"}, {31'd0, rsp_err1}, {31'd0, exp_err});
    step();
    check({tag, "_done"}, {31'd0, rsp_valid1}, 32'd0);
  endtask

  initial begin
    reset1 = 1'b0; req_valid1 = 1'b0; req_addr1 = 32'h0; rsp_ready1 = 1'b0;
    reset3 = 1'b0; req_valid3 = 1'b0; req_addr3 = 32'h0; rsp_ready3 = 1'b0;
`ifdef IMEM_WRITE_PORT_EN
    wr_en1 = 1'b0; wr_addr1 = 32'h0; wr_data1 = 32'h0; wr_strb1 = 4'h0;
`endif
    u_dut1.mem_r[0] = 32'h0050_0093;
    u_dut1.mem_r[1] = 32'h0010_0113;
    u_dut1.mem_r[2] = 32'h1122_3344;
    u_dut3.mem_r[1] = 32'h00A0_0113;
    u_dut3.mem_r[2] = 32'h0BAD_F00D;
    u_dut3.mem_r[3] = 32'hCAFE_0123;

    // Reset held for two edges.
    step();
    step();
    reset1 = 1'b1;
    reset3 = 1'b1;
    check("rst1_req_ready", {31'd0, req_ready1}, 32'd1);
    check("rst1_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    check("rst1_rsp_data", rsp_data1, 32'h0000_0013);
    check("rst1_rsp_err", {31'd0, rsp_err1}, 32'd0);
    check("rst3_req_ready", {31'd0, req_ready3}, 32'd1);
    check("rst3_rsp_data", rsp_data3, 32'h0000_0013);

    // LATENCY=1 reads and error fetches.
    fetch1("t2_addr0", 32'h0, 32'h0050_0093, 1'b0);
    fetch1("t4_misalign", 32'h2, 32'h0000_0013, 1'b1);
    fetch1("t4_range", 32'h1000, 32'h0000_0013, 1'b1);
    fetch1("t4_addr4", 32'h4, 32'h0010_0113, 1'b0);

`ifdef IMEM_WRITE_PORT_EN
    // Write and accept to the same word on one edge: old data returned.
    wr_en1 = 1'b1; wr_addr1 = 32'h8; wr_data1 = 32'hDEAD_BEEF; wr_strb1 = 4'b0011;
    req_valid1 = 1'b1; req_addr1 = 32'h8; rsp_ready1 = 1'b1;
    step();
    wr_en1 = 1'b0; req_valid1 = 1'b0;
    check("t6_old_data", rsp_data1, 32'h1122_3344);
    step();
    fetch1("t6_new_data", 32'h8, 32'h1122_BEEF, 1'b0);
    wr_en1 = 1'b1; wr_addr1 = 32'h6; wr_data1 = 32'hFFFF_FFFF; wr_strb1 = 4'b1111;
    step();
    wr_en1 = 1'b0;
    fetch1("t6_misaligned_wr", 32'h4, 32'h0010_0113, 1'b0);
`endif

    // LATENCY=3 with consumer back-pressure.
    req_valid3 = 1'b1; req_addr3 = 32'hC; rsp_ready3 = 1'b0;
    step();
    req_valid3 = 1'b0;
    check("t3_acc_valid", {31'd0, rsp_valid3}, 32'd0);
    check("t3_acc_ready", {31'd0, req_ready3}, 32'd0);
    step();
    check("t3_wait_valid", {31'd0, rsp_valid3}, 32'd0);
    step();
    check("t3_resp_valid", {31'd0, rsp_valid3}, 32'd1);
    check("t3_resp_data", rsp_data3, 32'hCAFE_0123);
    req_valid3 = 1'b1; req_addr3 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold_valid", {31'd0, rsp_valid3}, 32'd1);
      check("t3_hold_data", rsp_data3, 32'hCAFE_0123);
      check("t3_hold_ready", {31'd0, req_ready3}, 32'd0);
    end
    req_valid3 = 1'b0; rsp_ready3 = 1'b1;
    step();
    check("t3_idle_valid", {31'd0, rsp_valid3}, 32'd0);
    check("t3_idle_ready", {31'd0, req_ready3}, 32'd1);

    // Reset while a request waits: it is dropped.
    req_valid3 = 1'b1; req_addr3 = 32'h8;
    step();
    req_valid3 = 1'b0;
    reset3 = 1'b0;
    step();
    reset3 = 1'b1;
    check("t5_rst_ready", {31'd0, req_ready3}, 32'd1);
    check("t5_rst_data", rsp_data3, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_valid", {31'd0, rsp_valid3}, 32'd0);
    end
    req_valid3 = 1'b1; req_addr3 = 32'h4;
    step();
    req_valid3 = 1'b0;
    step();
    check("t5_wait_valid", {31'd0, rsp_valid3}, 32'd0);
    step();
    check("t5_resp_valid", {31'd0, rsp_valid3}, 32'd1);
    check("t5_resp_data", rsp_data3, 32'h00A0_0113);
    check("t5_resp_err", {31'd0, rsp_err3}, 32'd0);
    step();
    check("t5_done", {31'd0, rsp_valid3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
